// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state type, default 50 MHz timing and helpers for the WS2812 transmitter.
package ws2812_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} ws2812_state_t;
  localparam int T0H_50M          = 20;
  localparam int T1H_50M          = 40;
  localparam int BIT_CYCLES_50M   = 63;
  localparam int RESET_CYCLES_50M = 15000;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ws2812_bit_cell.sv
// ws2812_bit_cell: generates one NRZ pulse-width-coded bit; r_cnt is the 1-based cycle within the bit.
module ws2812_bit_cell #(
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int BIT_CYCLES = 63,
  parameter int CW         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_bit,
  output logic o_out,
  output logic o_fall,
  output logic o_bit_end
);
  logic [CW-1:0] r_cnt;
  logic          r_bit;
  logic          r_act;
  logic          r_out;
  logic [CW-1:0] w_thigh;
  assign w_thigh   = r_bit ? CW'(T1H) : CW'(T0H);
  assign o_bit_end = r_act && (r_cnt == CW'(BIT_CYCLES));
  assign o_fall    = r_act && (r_cnt == w_thigh);
  assign o_out     = r_out;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_bit <= 1'b0;
      r_act <= 1'b0;
      r_out <= 1'b0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
      r_bit <= i_bit;
      r_act <= 1'b1;
      r_out <= 1'b1;
    end else if (o_bit_end) begin
      r_cnt <= '0;
      r_act <= 1'b0;
      r_out <= 1'b0;
    end else if (r_act) begin
      r_cnt <= r_cnt + CW'(1);
      r_out <= r_cnt < w_thigh;
    end
  end
endmodule

// File: rtl/ws2812_transmitter.sv
// ws2812_transmitter: latches an RGB frame and shifts it out GRB, LED 0 first, to a WS2812 chain,
// then holds the line low for the latch period and pulses done.
module ws2812_transmitter
  import ws2812_pkg::*;
#(
  parameter int LEDS         = 50,
  parameter int T0H          = T0H_50M,
  parameter int T1H          = T1H_50M,
  parameter int BIT_CYCLES   = BIT_CYCLES_50M,
  parameter int RESET_CYCLES = RESET_CYCLES_50M
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [24*LEDS-1:0] led_rgb,
  input  logic              start,
  output logic              dout,
  output logic              busy,
  output logic              done
);
  localparam int N  = 24 * LEDS;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(max_int(BIT_CYCLES, RESET_CYCLES) + 1);
  if (!(T0H > 0 && T0H < T1H && T1H < BIT_CYCLES && RESET_CYCLES >= 1)) begin : g_bad_timing
    $error("ws2812_transmitter: need 0 < T0H < T1H < BIT_CYCLES and RESET_CYCLES >= 1");
  end
  ws2812_state_t r_state;
  logic [N-1:0]  r_shadow;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_lcnt;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  w_wire;
  logic          w_start;
  logic          w_last;
  logic          w_load;
  logic          w_bit;
  logic          w_fall;
  logic          w_bit_end;
  // Wire-order frame: MSB is the first bit on the line (LED 0, G7).
  for (genvar i = 0; i < LEDS; i++) begin : g_led
    assign w_wire[N-1-24*i -: 24] = {led_rgb[24*i+8 +: 8], led_rgb[24*i+16 +: 8], led_rgb[24*i +: 8]};
  end
  assign w_start = (r_state == IDLE) && start;
  assign w_last  = r_idx == IW'(N - 1);
  assign w_load  = w_start || (w_bit_end && !w_last);
  assign w_bit   = w_start ? w_wire[N-1] : r_shadow[N-1];
  assign busy    = r_busy;
  assign done    = r_done;
  ws2812_bit_cell #(
    .T0H(T0H), .T1H(T1H), .BIT_CYCLES(BIT_CYCLES), .CW(CW)
  ) u_cell (
    .clk(clk), .rst(rst), .i_load(w_load), .i_bit(w_bit),
    .o_out(dout), .o_fall(w_fall), .o_bit_end(w_bit_end)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_lcnt   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_shadow <= {w_wire[N-2:0], 1'b0};
          r_idx    <= '0;
          r_lcnt   <= '0;
          r_busy   <= 1'b1;
          r_state  <= HIGH;
        end
        HIGH: if (w_fall) r_state <= LOW;
        LOW: if (w_bit_end) begin
          if (w_last) begin
            r_lcnt  <= CW'(1);
            r_state <= LATCH;
          end else begin
            r_idx    <= r_idx + IW'(1);
            r_shadow <= r_shadow << 1;
            r_state  <= HIGH;
          end
        end
        LATCH: if (r_lcnt == CW'(RESET_CYCLES)) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_lcnt <= r_lcnt + CW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_transmitter.sv
// tb_ws2812_transmitter: directed checks of the WS2812 transmitter with a small 2-LED configuration.
module tb_ws2812_transmitter;
  localparam int LEDS = 2, T0H = 2, T1H = 4, BC = 6, RC = 10;
  localparam int NB = 24 * LEDS;
  localparam int DONE_C = NB * BC + RC + 1;
  localparam logic [47:0] W_RB    = 48'h00FF00_0000FF;
  localparam logic [47:0] W_MIX   = 48'h341256_C3A50F;
  localparam logic [47:0] W_ONES  = 48'hFFFFFF_FFFFFF;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [47:0] led_rgb = '0;
  logic        dout, busy, done;
  int          n_checks = 0;
  int          n_fail = 0;

  ws2812_transmitter #(
    .LEDS(LEDS), .T0H(T0H), .T1H(T1H), .BIT_CYCLES(BC), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .led_rgb(led_rgb), .start(start),
    .dout(dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, c, got, exp);
    end
  endtask

  function automatic logic exp_dout(input logic [47:0] w, input int c);
    int k, p;
    if (c < 1 || c > NB * BC) return 1'b0;
    k = (c - 1) / BC;
    p = (c - 1) % BC + 1;
    return p <= (w[47-k] ? T1H : T0H);
  endfunction

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_dout"}, 0, dout, 0);
    chk({tag, "_busy"}, 0, busy, 0);
    chk({tag, "_done"}, 0, done, 0);
  endtask

  // Start is sampled at edge 0; cycle c is observed at the negedge after edge c-1.
  task automatic frame(input logic [47:0] w, input int s_from, input int s_to,
                       input int chg, input logic [47:0] nrgb);
    int   rises;
    logic prev;
    rises = 0;
    prev  = dout;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= DONE_C; c++) begin
      @(negedge clk);
      chk("dout", c, dout, exp_dout(w, c));
      chk("busy", c, busy, c < DONE_C);
      chk("done", c, done, c == DONE_C);
      if (dout && !prev) rises++;
      prev  = dout;
      start = (c >= s_from) && (c <= s_to);
      if (c == chg) led_rgb = nrgb;
    end
    chk("rises", 0, rises, NB);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dout", 0, dout, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, done, 0);
    rst = 1'b1;
    idle_chk("idle");

    led_rgb = {24'h0000FF, 24'hFF0000};
    frame(W_RB, 0, 0, 0, '0);
    idle_chk("single_after");

    frame(W_RB, 4, 99, 9, {24'h123456, 24'h654321});
    idle_chk("ignore_after");

    led_rgb = {24'hA5C30F, 24'h123456};
    frame(W_MIX, 1, DONE_C, 0, '0);
    frame(W_MIX, 1, DONE_C - 2, 0, '0);
    idle_chk("b2b_after");

    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    chk("pre_rst_dout", 50, dout, 1);
    chk("pre_rst_busy", 50, busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_dout", 50, dout, 0);
    chk("async_busy", 50, busy, 0);
    chk("async_done", 50, done, 0);
    for (int c = 0; c < 3; c++) idle_chk("in_rst");
    rst = 1'b1;
    idle_chk("rst_release");
    frame(W_MIX, 0, 0, 0, '0);
    idle_chk("post_rst_after");

    led_rgb = {24'hFFFFFF, 24'hFFFFFF};
    frame(W_ONES, 0, 0, 0, '0);
    idle_chk("ones_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
